// File: rtl/apb_mem_bridge.sv
// APB3 slave front-end for the LIN register data memory.
// Turns APB setup/access phases into the memory's write strobe and
// read address. Reads return the memory's registered data after one
// wait state. Misaligned or out-of-range accesses complete with PSLVERR
// and are never forwarded to the memory.
module apb_mem_bridge #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              SWR_en,
   output logic [31:0]       SWR_ADDR,
   output logic [DATA_W-1:0] SWR_data,
   output logic [31:0]       SRD_ADDR,
   input  logic [DATA_W-1:0] SRD_data
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_WAIT,
      RD_DATA,
      ERR
   } state_t;

   state_t              state_q, state_d;
   logic                swr_en_q, swr_en_d;
   logic [31:0]         swr_addr_q, swr_addr_d;
   logic [DATA_W-1:0]   swr_data_q, swr_data_d;
   logic [31:0]         srd_addr_q, srd_addr_d;
   logic                pready_q, pready_d;
   logic                pslverr_q, pslverr_d;

   logic [31:0]         idx_ext;
   logic                addr_err;
   logic                setup;

   // Address decode: word index zero-extended to 32 bits, error on misalignment or beyond the memory depth.
   always_comb begin
      idx_ext                = '0;
      idx_ext[ADDR_W-3:0]    = PADDR[ADDR_W-1:2];
      addr_err               = (PADDR[1:0] != 2'b00) || (idx_ext >= 32'(DEPTH));
      setup                  = PSEL && !PENABLE;
   end

   // State and registered outputs; reset returns everything to IDLE with all outputs cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         swr_en_q   <= 1'b0;
         swr_addr_q <= '0;
         swr_data_q <= '0;
         srd_addr_q <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         swr_en_q   <= swr_en_d;
         swr_addr_q <= swr_addr_d;
         swr_data_q <= swr_data_d;
         srd_addr_q <= srd_addr_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
      end
   end

   // Next-state: a new request is only taken from IDLE; dropping PSEL mid-transfer aborts to IDLE.
   always_comb begin
      state_d = IDLE;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               if (addr_err) begin
                  state_d = ERR;
               end else if (PWRITE) begin
                  state_d = WR;
               end else begin
                  state_d = RD_WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT: state_d = PSEL ? RD_DATA : IDLE;
         WR:      state_d = IDLE;
         RD_DATA: state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values: strobes/handshake default low, memory address/data hold between transfers.
   always_comb begin
      swr_en_d   = 1'b0;
      pready_d   = 1'b0;
      pslverr_d  = 1'b0;
      swr_addr_d = swr_addr_q;
      swr_data_d = swr_data_q;
      srd_addr_d = srd_addr_q;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               if (addr_err) begin
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else if (PWRITE) begin
                  swr_en_d   = 1'b1;
                  swr_addr_d = idx_ext;
                  swr_data_d = PWDATA;
                  pready_d   = 1'b1;
               end else begin
                  srd_addr_d = idx_ext;
               end
            end
         end
         RD_WAIT: pready_d = PSEL;
         default: begin
            pready_d = 1'b0;
         end
      endcase
   end

   // Read data is only presented while the memory's registered output is valid.
   always_comb begin
      PRDATA = (state_q == RD_DATA) ? SRD_data : '0;
   end

   assign SWR_en   = swr_en_q;
   assign SWR_ADDR = swr_addr_q;
   assign SWR_data = swr_data_q;
   assign SRD_ADDR = srd_addr_q;
   assign PREADY   = pready_q;
   assign PSLVERR  = pslverr_q;

endmodule

// File: doc/apb_mem_bridge.md
Name: apb_mem_bridge

Overview:
- APB3 slave front-end that sits directly upstream of the LIN register data memory.
- Converts APB setup/access phases into the memory's write strobe, write address/data and read address.
- Returns the memory's registered read data on PRDATA with one wait state.
- Flags misaligned or out-of-range accesses with PSLVERR and never lets them reach the memory.

Parameters:
- ADDR_W, 12, width of PADDR in bits.
- DEPTH, 8, number of 32-bit words in the downstream memory; legal word index is 0..DEPTH-1.
- DATA_W, 32, APB and memory data width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- PSEL  input  1  APB slave select.
- PENABLE  input  1  APB access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  APB byte address.
- PWDATA  input  DATA_W  APB write data.
- PRDATA  output  DATA_W  APB read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  transfer error; valid only while PREADY=1.
- SWR_en  output  1  memory write enable, one-cycle pulse.
- SWR_ADDR  output  32  memory write word index, zero-extended.
- SWR_data  output  DATA_W  memory write data.
- SRD_ADDR  output  32  memory read word index, zero-extended.
- SRD_data  input  DATA_W  memory read data, registered inside the memory one cycle after SRD_ADDR.

Behaviour:
- Reset: clk, synchronous, active-high; reset=1 sampled at a rising edge forces the state to IDLE.
  - Outputs go to 0: SWR_en, SWR_ADDR, SWR_data, SRD_ADDR, PREADY, PSLVERR, PRDATA.
  - Reset overrides any transfer in progress. No memory write is issued in the reset cycle.
- Decode:
  - idx = PADDR[ADDR_W-1:2].
  - err = (PADDR[1:0] != 0) or (idx >= DEPTH).
  - Decode is evaluated only in the setup phase (PSEL=1, PENABLE=0) while in IDLE.
- States: IDLE, WR, RD_WAIT, RD_DATA, ERR. All outputs except PRDATA are registered.
- IDLE, setup phase sampled at edge E0:
  - err=1: go to ERR; PREADY<=1, PSLVERR<=1; no SWR_en, SRD_ADDR unchanged.
  - PWRITE=1, no error: go to WR; SWR_en<=1, SWR_ADDR<=idx, SWR_data<=PWDATA, PREADY<=1.
  - PWRITE=0, no error: go to RD_WAIT; SRD_ADDR<=idx, PREADY<=0.
  - Anything else: stay in IDLE; outputs hold, SWR_en=0, PREADY=0.
- WR: access cycle completes at E1 (zero wait states); the memory captures the write at the same edge. Next state IDLE; SWR_en<=0, PREADY<=0.
- RD_WAIT: one wait state; the memory registers mem[idx] at E1. Next state RD_DATA; PREADY<=1.
- RD_DATA:
  - PRDATA = SRD_data (combinational pass-through, gated).
  - Transfer completes at E2. Next state IDLE; PREADY<=0.
- ERR: completes at E1 with PSLVERR=1, then IDLE; PREADY<=0, PSLVERR<=0.
- PRDATA is 0 in every state except RD_DATA.
- Protocol violation: PSEL=0 in any non-IDLE state aborts to IDLE and clears SWR_en/PREADY/PSLVERR. A write already pulsed is not retracted.
- Back-to-back transfers: the next setup phase can only be sampled the edge after completion, so no new-request/completion collision is possible. Throughput is 1 write per 2 cycles, 1 read per 3 cycles.
- SWR_ADDR, SWR_data and SRD_ADDR hold their last value between transfers. Upper bits are always 0.
- PWRITE/PADDR/PWDATA changes during the access phase are ignored; values are captured at setup.

Test Plan:
- Reset: assert reset 2 cycles mid-read (state RD_WAIT) -> next cycle all outputs 0, state IDLE, no SWR_en pulse.
- Write: PADDR=0x00C, PWDATA=0xDEADBEEF -> SWR_en=1 for exactly 1 cycle with SWR_ADDR=3, SWR_data=0xDEADBEEF; PREADY=1 in first access cycle, PSLVERR=0.
- Read-back: after write, read PADDR=0x00C -> PREADY=0 first access cycle, PREADY=1 second with PRDATA=0xDEADBEEF; SRD_ADDR=3.
- Errors: write PADDR=0x020 (idx 8), then read PADDR=0x006 (misaligned) -> each completes in 1 access cycle with PREADY=1, PSLVERR=1, SWR_en never asserted, PRDATA=0.
- Back-to-back: write 0x11111111..0x88888888 to idx 0..7, then read idx 7 down to 0 -> every read returns the matching value, 2 cycles/write, 3 cycles/read.
- Abort: drop PSEL during RD_WAIT -> returns to IDLE, PREADY stays 0; a following normal read of idx 0 returns 0x11111111.
